dma_priority_arbiter: RTL and testbench
=======================================

# dma_priority_arbiter

Channel priority and bus-request sequencer for the 4-channel DMA controller. Combines hardware DREQs, the mask register and software requests into one effective request vector. Runs the HRQ/HLDA hold handshake with the CPU and selects one winning channel under fixed or rotating priority. Drives DACK to that channel for the whole service and reports the channel to the timing-control FSM.

## Interface
Parameters:
- NUM_CH, 4: channel count. Fixed at 4; priorityOrder encoding depends on it.
- CH_W, 2: channel index width.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  reset, synchronous, active-high.
- DREQ  in  4  hardware channel requests, active-high.
- maskReg  in  4  per-channel mask from the register file; 1 = masked.
- softwareReq  in  4  request-register bits; bypass the mask.
- controllerDisable  in  1  commandReg[2]; blocks new arbitration.
- rotatingPriority  in  1  commandReg[4]; 1 = rotating, 0 = fixed.
- HLDA  in  1  hold acknowledge from the CPU.
- serviceDone  in  1  one-cycle pulse from timing control marking the end of the current service (EOP, terminal count or burst end).
- HRQ  out  1  hold request to the CPU.
- DACK  out  4  one-hot channel acknowledge, active-high.
- grantValid  out  1  high while a channel holds the grant.
- activeChannel  out  2  index of the granted channel; valid only when grantValid is high.
- priorityOrder  out  8  {slot3,slot2,slot1,slot0}; each slot holds a 2-bit channel ID. slot0 is the highest priority.

## Operation
- Effective request: effReq = ((DREQ & ~maskReg) | softwareReq) & {4{~controllerDisable}}.
- Winner: the first slot, scanning slot0 to slot3, whose channel has effReq set.
- State machine with one-hot states IDLE, REQ, GRANT:
  - IDLE, effReq != 0: set HRQ and go to REQ.
  - REQ, effReq == 0 (request withdrawn before HLDA): clear HRQ and go to IDLE.
  - REQ, HLDA = 1 and effReq != 0: latch the winner into activeChannel, set DACK[winner] and grantValid, go to GRANT. HRQ stays high.
  - GRANT: activeChannel, DACK and HRQ are held stable.
    - No preemption by higher-priority requests.
    - Mask changes, DREQ deassertion and controllerDisable have no effect.
  - GRANT, serviceDone = 1: clear DACK, grantValid and HRQ; update priorityOrder; go to IDLE.
  - GRANT, HLDA = 0 without serviceDone (CPU revoked hold): clear DACK, grantValid and HRQ; go to IDLE; priorityOrder unchanged.
- Priority update:
  - Rotating mode, after servicing channel k: slot0 = k+1, slot1 = k+2, slot2 = k+3, slot3 = k, all mod 4.
  - Fixed mode: priorityOrder is loaded with 8'b11_10_01_00 on every clock edge, including during GRANT.
- Reset, which takes precedence over every other input:
  - State IDLE.
  - HRQ = 0, DACK = 4'b0000, grantValid = 0, activeChannel = 2'b00.
  - priorityOrder = 8'b11_10_01_00.
- Reset mid-service: all outputs return to reset values on the next edge, and no rotation is applied.

## Timing
- effReq first nonzero in IDLE at edge N: HRQ = 1 after edge N.
- HLDA sampled high in REQ at edge M: DACK and grantValid high after edge M. The winner is computed from effReq and priorityOrder at edge M.
- serviceDone at edge P: DACK = 0, HRQ = 0 and the new priorityOrder after edge P.
- HRQ is low for at least one full cycle between services; the earliest re-assertion is after edge P+1.
- If serviceDone and HLDA = 0 occur at the same edge, treat it as serviceDone: rotation applies.
- An HLDA already high while in IDLE is ignored; the grant occurs only from REQ.
- Exactly one DACK bit is high when grantValid = 1; DACK = 0 otherwise.

## Test plan
- Reset: hold RESET for 2 cycles with DREQ = 4'b1111 and HLDA = 1. Required: HRQ = 0, DACK = 0000, grantValid = 0 and priorityOrder = 8'b11_10_01_00 after each reset edge.
- Fixed priority: DREQ = 4'b1010, rotatingPriority = 0, HLDA driven one cycle after HRQ. Required: HRQ 1 cycle after DREQ, DACK = 0010 one cycle after HLDA, priorityOrder unchanged after serviceDone.
- Rotating priority: service ch1, then present DREQ = 4'b0011. Required: priorityOrder = 8'b01_00_11_10 after serviceDone; next grant goes to ch0 (slot2), not ch1 (slot3).
- Mask and software request: maskReg = 4'b0001, DREQ = 4'b0001. Required: HRQ stays 0. Then softwareReq = 4'b0001. Required: HRQ = 1, and DACK = 0001 after HLDA.
- Withdrawal and revoke:
  - DREQ dropped while in REQ. Required: HRQ = 0 next cycle, no DACK.
  - HLDA dropped in GRANT. Required: DACK = 0000, HRQ = 0 next cycle, priorityOrder unchanged.
- No preemption / reset mid-service:
  - Grant ch2, then raise DREQ[0]. Required: DACK stays 0100 until serviceDone.
  - Separately, RESET during GRANT. Required: DACK = 0000 and priorityOrder = 8'b11_10_01_00 next cycle.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// DMA channel priority arbiter and HRQ/HLDA bus-request sequencer.
// Selects one channel under fixed or rotating priority and holds DACK for the service.
module dma_priority_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [NUM_CH-1:0]      DREQ,
    input  logic [NUM_CH-1:0]      maskReg,
    input  logic [NUM_CH-1:0]      softwareReq,
    input  logic                   controllerDisable,
    input  logic                   rotatingPriority,
    input  logic                   HLDA,
    input  logic                   serviceDone,
    output logic                   HRQ,
    output logic [NUM_CH-1:0]      DACK,
    output logic                   grantValid,
    output logic [CH_W-1:0]        activeChannel,
    output logic [NUM_CH*CH_W-1:0] priorityOrder
);

    localparam logic [NUM_CH*CH_W-1:0] DEFAULT_ORDER = 8'b11_10_01_00;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        REQ   = 3'b010,
        GRANT = 3'b100
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          active_q, active_d;
    logic [NUM_CH*CH_W-1:0]   order_q, order_d;
    logic [NUM_CH*CH_W-1:0]   rot_order;
    logic [NUM_CH-1:0]        eff_req;
    logic [CH_W-1:0]          win_ch;
    logic                     service_end;

    // Software requests bypass the mask; disable blocks everything.
    always_comb begin
        eff_req = ((DREQ & ~maskReg) | softwareReq) & {NUM_CH{~controllerDisable}};
    end

    // Scan slots from lowest priority upward so slot0 overrides last.
    always_comb begin
        win_ch = '0;
        for (int s = NUM_CH - 1; s >= 0; s--) begin
            if (eff_req[order_q[s*CH_W +: CH_W]]) begin
                win_ch = order_q[s*CH_W +: CH_W];
            end
        end
    end

    // Serviced channel drops to slot3; its successor takes slot0.
    always_comb begin
        rot_order = '0;
        for (int s = 0; s < NUM_CH; s++) begin
            rot_order[s*CH_W +: CH_W] = active_q + CH_W'(s + 1);
        end
    end

    // Next-state logic for the hold handshake and grant latch.
    always_comb begin
        state_d     = state_q;
        active_d    = active_q;
        service_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eff_req) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!(|eff_req)) begin
                    state_d = IDLE;
                end else if (HLDA) begin
                    state_d  = GRANT;
                    active_d = win_ch;
                end
            end
            GRANT: begin
                if (serviceDone) begin
                    state_d     = IDLE;
                    service_end = 1'b1;
                end else if (!HLDA) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fixed mode reloads the default order every cycle.
    always_comb begin
        if (!rotatingPriority) begin
            order_d = DEFAULT_ORDER;
        end else if (service_end) begin
            order_d = rot_order;
        end else begin
            order_d = order_q;
        end
    end

    // State, grant and priority registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            active_q <= '0;
            order_q  <= DEFAULT_ORDER;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            order_q  <= order_d;
        end
    end

    // One-hot acknowledge for the granted channel only.
    always_comb begin
        DACK = '0;
        if (state_q == GRANT) begin
            DACK[active_q] = 1'b1;
        end
    end

    assign HRQ           = (state_q != IDLE);
    assign grantValid    = (state_q == GRANT);
    assign activeChannel = active_q;
    assign priorityOrder = order_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Testbench for dma_priority_arbiter.
// Directed vector table, hand sequences and random traffic against a reference model.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ, maskReg, softwareReq;
    logic       controllerDisable, rotatingPriority, HLDA, serviceDone;
    logic       HRQ, grantValid;
    logic [3:0] DACK;
    logic [1:0] activeChannel;
    logic [7:0] priorityOrder;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: hold request flag, owning channel (-1 none), slot array.
    bit         m_hrq;
    int         m_owner;
    logic [1:0] m_order[4];

    typedef struct packed {
        logic       rst;
        logic [3:0] dreq;
        logic [3:0] mask;
        logic [3:0] sw;
        logic       dis;
        logic       rot;
        logic       hlda;
        logic       sd;
        logic       hrq;
        logic       gv;
        logic [3:0] dack;
        logic [7:0] prio;
    } vec_t;

    vec_t tbl[$];

    dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .DREQ(DREQ),
        .maskReg(maskReg),
        .softwareReq(softwareReq),
        .controllerDisable(controllerDisable),
        .rotatingPriority(rotatingPriority),
        .HLDA(HLDA),
        .serviceDone(serviceDone),
        .HRQ(HRQ),
        .DACK(DACK),
        .grantValid(grantValid),
        .activeChannel(activeChannel),
        .priorityOrder(priorityOrder)
    );

    always #5 CLK = ~CLK;

    task automatic add(input logic rst, input logic [3:0] dreq, mask, sw,
                       input logic dis, rot, hlda, sd, input logic hrq, gv,
                       input logic [3:0] dack, input logic [7:0] prio);
        vec_t v;
        v.rst = rst; v.dreq = dreq; v.mask = mask; v.sw = sw;
        v.dis = dis; v.rot = rot; v.hlda = hlda; v.sd = sd;
        v.hrq = hrq; v.gv = gv; v.dack = dack; v.prio = prio;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] dreq, mask, sw,
                         input logic dis, rot, hlda, sd);
        RESET = rst; DREQ = dreq; maskReg = mask; softwareReq = sw;
        controllerDisable = dis; rotatingPriority = rot;
        HLDA = hlda; serviceDone = sd;
    endtask

    task automatic check(input string name, input logic [31:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic model_step();
        bit eff[4];
        bit any;
        int win;
        int served;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            eff[i] = !controllerDisable &&
                     ((DREQ[i] && !maskReg[i]) || softwareReq[i]);
            if (eff[i]) any = 1;
        end
        if (RESET) begin
            m_hrq = 0;
            m_owner = -1;
            for (int s = 0; s < 4; s++) m_order[s] = 2'(s);
            return;
        end
        win = -1;
        for (int s = 0; s < 4; s++)
            if (win < 0 && eff[m_order[s]]) win = int'(m_order[s]);
        served = -1;
        if (m_owner >= 0) begin
            if (serviceDone) begin
                served = m_owner; m_owner = -1; m_hrq = 0;
            end else if (!HLDA) begin
                m_owner = -1; m_hrq = 0;
            end
        end else if (m_hrq) begin
            if (!any) m_hrq = 0;
            else if (HLDA) m_owner = win;
        end else if (any) begin
            m_hrq = 1;
        end
        if (!rotatingPriority) begin
            for (int s = 0; s < 4; s++) m_order[s] = 2'(s);
        end else if (served >= 0) begin
            for (int s = 0; s < 4; s++) m_order[s] = 2'((served + 1 + s) % 4);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    initial begin
        logic [14:0] exp_v, act_v;
        logic [3:0]  e_dack;
        logic        rot_mode;

        m_hrq = 0;
        m_owner = -1;
        for (int s = 0; s < 4; s++) m_order[s] = 2'(s);
        drive(1, 4'hF, 0, 0, 0, 0, 1, 0);

        // rst dreq mask sw dis rot hlda sd | hrq gv dack prio
        add(1, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 8'hE4);
        add(1, 4'hF, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'hA, 0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 8'hE4);
        add(0, 4'hA, 0, 0, 0, 0, 1, 0, 1, 1, 4'h2, 8'hE4);
        add(0, 4'hA, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h2, 0, 0, 0, 1, 0, 0, 1, 0, 4'h0, 8'hE4);
        add(0, 4'h2, 0, 0, 0, 1, 1, 0, 1, 1, 4'h2, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 1, 1, 1, 0, 0, 4'h0, 8'h4E);
        add(0, 4'h3, 0, 0, 0, 1, 0, 0, 1, 0, 4'h0, 8'h4E);
        add(0, 4'h3, 0, 0, 0, 1, 1, 0, 1, 1, 4'h1, 8'h4E);
        add(0, 4'h3, 0, 0, 0, 1, 1, 1, 0, 0, 4'h0, 8'h39);
        add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h1, 1, 1, 0, 0, 0, 0, 1, 0, 4'h0, 8'hE4);
        add(0, 4'h1, 1, 1, 0, 0, 1, 0, 1, 1, 4'h1, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h4, 0, 0, 0, 0, 1, 0, 1, 0, 4'h0, 8'hE4);
        add(0, 4'h4, 0, 0, 0, 0, 1, 0, 1, 1, 4'h4, 8'hE4);
        add(0, 4'h4, 0, 0, 0, 0, 1, 1, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'hF, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'hF, 0, 4'hF, 1, 0, 0, 0, 0, 0, 4'h0, 8'hE4);
        add(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'hE4);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].dreq, tbl[i].mask, tbl[i].sw,
                  tbl[i].dis, tbl[i].rot, tbl[i].hlda, tbl[i].sd);
            step();
            check($sformatf("vec%0d", i),
                  {18'd0, HRQ, grantValid, DACK, priorityOrder},
                  {18'd0, tbl[i].hrq, tbl[i].gv, tbl[i].dack, tbl[i].prio});
        end

        // Request withdrawn in REQ, even with HLDA arriving.
        drive(0, 4'h8, 0, 0, 0, 0, 0, 0); step();
        check("withdraw_req", {31'd0, HRQ}, 32'd1);
        drive(0, 4'h0, 0, 0, 0, 0, 1, 0); step();
        check("withdraw", {27'd0, HRQ, DACK}, 32'd0);
        drive(0, 4'h0, 0, 0, 0, 0, 0, 0); step();

        // CPU revokes hold during grant in rotating mode.
        drive(0, 4'h2, 0, 0, 0, 1, 0, 0); step();
        drive(0, 4'h2, 0, 0, 0, 1, 1, 0); step();
        check("revoke_grant", {28'd0, DACK}, 32'h2);
        drive(0, 4'h2, 0, 0, 0, 1, 0, 0); step();
        check("revoke", {19'd0, HRQ, DACK, priorityOrder}, {19'd0, 1'b0, 4'h0, 8'hE4});
        drive(0, 4'h0, 0, 0, 0, 1, 0, 0); step();

        // No preemption; mask and disable ignored while granted.
        drive(0, 4'h4, 0, 0, 0, 0, 0, 0); step();
        drive(0, 4'h4, 0, 0, 0, 0, 1, 0); step();
        check("hold_grant", {28'd0, DACK}, 32'h4);
        drive(0, 4'h5, 0, 0, 0, 0, 1, 0); step();
        check("no_preempt0", {28'd0, DACK}, 32'h4);
        drive(0, 4'h1, 4'hF, 0, 1, 0, 1, 0); step();
        check("no_preempt1", {27'd0, HRQ, DACK}, 32'h14);
        drive(0, 4'h5, 0, 0, 0, 0, 1, 1); step();
        check("preempt_done", {27'd0, HRQ, DACK}, 32'd0);
        drive(0, 4'h0, 0, 0, 0, 0, 0, 0); step();

        // Reset in the middle of a rotating-mode service.
        drive(0, 4'h8, 0, 0, 0, 1, 0, 0); step();
        drive(0, 4'h8, 0, 0, 0, 1, 1, 0); step();
        check("rst_grant", {28'd0, DACK}, 32'h8);
        drive(1, 4'h8, 0, 0, 0, 1, 1, 1); step();
        check("rst_mid", {18'd0, HRQ, grantValid, DACK, priorityOrder}, {18'd0, 6'd0, 8'hE4});

        // serviceDone together with HLDA low still rotates.
        drive(0, 4'h4, 0, 0, 0, 1, 0, 0); step();
        drive(0, 4'h4, 0, 0, 0, 1, 1, 0); step();
        check("sd_grant", {28'd0, DACK}, 32'h4);
        drive(0, 4'h0, 0, 0, 0, 1, 0, 1); step();
        check("sd_hlda_low", {23'd0, HRQ, priorityOrder}, {23'd0, 1'b0, 8'h93});

        // Randomized traffic against the reference model.
        rot_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) rot_mode = ~rot_mode;
            drive(($urandom_range(0, 63) == 0),
                  4'($urandom),
                  ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 15) == 0),
                  rot_mode,
                  m_hrq ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0),
                  (m_owner >= 0) ? ($urandom_range(0, 3) == 0)
                                 : ($urandom_range(0, 31) == 0));
            step();
            e_dack = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
            exp_v = {m_hrq, (m_owner >= 0), e_dack,
                     m_order[3], m_order[2], m_order[1], m_order[0],
                     (m_owner >= 0) ? 2'(m_owner) : 2'b00};
            act_v = {HRQ, grantValid, DACK, priorityOrder,
                     grantValid ? activeChannel : 2'b00};
            check($sformatf("rand%0d", c), {17'd0, act_v}, {17'd0, exp_v});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
